// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int NUM_REQ        = 2;
  localparam int DEFAULT_ADDR_W = 2;
  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between two requesters.
// On contention the requester that did not own the memory last wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_last_owner,
  output logic               o_valid,
  output logic               o_winner
);

  always_comb begin
    o_valid  = |i_req;
    o_winner = 1'b0;
    if (&i_req) begin
      o_winner = ~i_last_owner;
    end else if (i_req[1]) begin
      o_winner = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter: IDLE -> CMD (-> RESP on reads), all outputs registered.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating priority on contention; otherwise requester 0 always wins.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              we,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  wdata,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              rvalid,
  output logic [NUM_REQ-1:0][DATA_W-1:0]  rdata,
  output logic [ADDR_W-1:0]               mem_address,
  output logic                            mem_write_en,
  output logic                            mem_read_en,
  output logic [DATA_W-1:0]               mem_data_wr,
  input  logic [DATA_W-1:0]               mem_data_rd
);

  state_t r_state, w_next_state;

  logic r_we;
  logic r_owner;

  logic [NUM_REQ-1:0]             r_gnt, w_gnt;
  logic [NUM_REQ-1:0]             r_rvalid, w_rvalid;
  logic [NUM_REQ-1:0][DATA_W-1:0] r_rdata, w_rdata;
  logic [ADDR_W-1:0]              r_mem_address, w_mem_address;
  logic                           r_mem_write_en, w_mem_write_en;
  logic                           r_mem_read_en, w_mem_read_en;
  logic [DATA_W-1:0]              r_mem_data_wr, w_mem_data_wr;

  logic w_accept;
  logic w_pick_valid;
  logic w_winner;
  logic w_last_owner;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last_owner;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_owner <= 1'b1;
    end else if (w_accept) begin
      r_last_owner <= w_winner;
    end
  end

  assign w_last_owner = r_last_owner;
`else
  // Pinning last_owner to 1 makes the picker always favour requester 0.
  assign w_last_owner = 1'b1;
`endif

  mem_arb_pick u_pick (
    .i_req        (req),
    .i_last_owner (w_last_owner),
    .o_valid      (w_pick_valid),
    .o_winner     (w_winner)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state   = r_state;
    w_accept       = 1'b0;
    w_gnt          = '0;
    w_rvalid       = '0;
    w_rdata        = r_rdata;
    w_mem_address  = '0;
    w_mem_write_en = 1'b0;
    w_mem_read_en  = 1'b0;
    w_mem_data_wr  = '0;

    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_accept          = 1'b1;
          w_next_state      = CMD;
          w_gnt[w_winner]   = 1'b1;
          w_mem_address     = addr[w_winner];
          if (we[w_winner]) begin
            w_mem_write_en = 1'b1;
            w_mem_data_wr  = wdata[w_winner];
          end else begin
            w_mem_read_en = 1'b1;
          end
        end
      end
      CMD: begin
        w_next_state = r_we ? IDLE : RESP;
      end
      RESP: begin
        // Memory data is valid now, one cycle after the read strobe.
        w_next_state     = IDLE;
        w_rvalid[r_owner] = 1'b1;
        w_rdata[r_owner]  = mem_data_rd;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_we           <= 1'b0;
      r_owner        <= 1'b0;
      r_gnt          <= '0;
      r_rvalid       <= '0;
      r_rdata        <= '0;
      r_mem_address  <= '0;
      r_mem_write_en <= 1'b0;
      r_mem_read_en  <= 1'b0;
      r_mem_data_wr  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_we    <= we[w_winner];
        r_owner <= w_winner;
      end
      r_gnt          <= w_gnt;
      r_rvalid       <= w_rvalid;
      r_rdata        <= w_rdata;
      r_mem_address  <= w_mem_address;
      r_mem_write_en <= w_mem_write_en;
      r_mem_read_en  <= w_mem_read_en;
      r_mem_data_wr  <= w_mem_data_wr;
    end
  end

  assign gnt          = r_gnt;
  assign rvalid       = r_rvalid;
  assign rdata        = r_rdata;
  assign mem_address  = r_mem_address;
  assign mem_write_en = r_mem_write_en;
  assign mem_read_en  = r_mem_read_en;
  assign mem_data_wr  = r_mem_data_wr;

endmodule
